// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART host link engine.
// Debug command bytes match the MIPS debug unit's command decoder.
package uart_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam logic KIND_CMD  = 1'b0;
  localparam logic KIND_WORD = 1'b1;

  localparam logic [7:0] CMD_LOAD      = 8'h02;
  localparam logic [7:0] CMD_REGS      = 8'h03;
  localparam logic [7:0] CMD_LATCH_IF  = 8'h04;
  localparam logic [7:0] CMD_LATCH_ID  = 8'h05;
  localparam logic [7:0] CMD_LATCH_EX  = 8'h06;
  localparam logic [7:0] CMD_LATCH_MEM = 8'h07;
  localparam logic [7:0] CMD_CONT      = 8'h08;
  localparam logic [7:0] CMD_STEP_MODE = 8'h09;
  localparam logic [7:0] CMD_STEP      = 8'h0A;
  localparam logic [7:0] CMD_END_LOAD  = 8'h0C;
  localparam logic [7:0] CMD_RUN       = 8'h0D;

  // Width of an index that must address n entries (never zero).
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_host_link_if.sv
// Host request / uart_tx / uart_rx signal bundle for uart_host_link.
// slave is the link engine side, master the host/sequencer side.
interface uart_host_link_if #(
  parameter int WORD_BYTES = 4
);
  logic                    i_req_valid;
  logic                    i_req_kind;
  logic [8*WORD_BYTES-1:0] i_req_payload;
  logic                    o_req_ready;

  logic                    o_tx_start;
  logic [7:0]              o_tx_data;
  logic                    i_tx_done;

  logic                    i_rx_valid;
  logic [7:0]              i_rx_data;
  logic [8*WORD_BYTES-1:0] o_rx_word;
  logic                    o_rx_word_valid;
  logic                    o_rx_timeout;

  modport slave (
    input  i_req_valid,
    input  i_req_kind,
    input  i_req_payload,
    output o_req_ready,
    output o_tx_start,
    output o_tx_data,
    input  i_tx_done,
    input  i_rx_valid,
    input  i_rx_data,
    output o_rx_word,
    output o_rx_word_valid,
    output o_rx_timeout
  );

  modport master (
    output i_req_valid,
    output i_req_kind,
    output i_req_payload,
    input  o_req_ready,
    input  o_tx_start,
    input  o_tx_data,
    output i_tx_done,
    output i_rx_valid,
    output i_rx_data,
    input  o_rx_word,
    input  o_rx_word_valid,
    input  o_rx_timeout
  );
endinterface

// File: rtl/uart_rx_word_assembler.sv
// Packs received UART bytes into words, LSB lane first, and drops
// partial words that stall longer than TIMEOUT_CYCLES clocks.
module uart_rx_word_assembler
  import uart_link_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rx_valid,
  input  logic [7:0]              i_rx_data,
  output logic [8*WORD_BYTES-1:0] o_rx_word,
  output logic                    o_rx_word_valid,
  output logic                    o_rx_timeout
);

  localparam int IW = idx_width(WORD_BYTES);
  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  logic [WORD_BYTES-1:0][7:0] lane_q, lane_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       wv_q, wv_d;
  logic                       to_q, to_d;
  logic                       expire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lane_q <= '0;
      idx_q  <= '0;
      tmo_q  <= '0;
      wv_q   <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
      tmo_q  <= tmo_d;
      wv_q   <= wv_d;
      to_q   <= to_d;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    tmo_d  = tmo_q;
    wv_d   = 1'b0;
    to_d   = 1'b0;
    expire = TMO_EN && (idx_q != '0) && (tmo_q == TLIM);
    if (i_rx_valid) begin
      lane_d[idx_q] = i_rx_data;
      tmo_d         = '0;
      if (idx_q == LAST) begin
        idx_d = '0;
        wv_d  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else if (expire) begin
      idx_d = '0;
      tmo_d = '0;
      to_d  = 1'b1;
    end else if ((idx_q != '0) && (tmo_q != '1)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign o_rx_word       = lane_q;
  assign o_rx_word_valid = wv_q;
  assign o_rx_timeout    = to_q;

endmodule

// File: rtl/uart_host_link.sv
// Host-side UART debug link: serialises commands/words into uart_tx
// bytes and reassembles uart_rx bytes into words.
module uart_host_link
  import uart_link_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_host_link_if.slave   bus
);

  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int PW = 8 * WORD_BYTES;

  tx_state_e       state_q, state_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the bytes still owed, including the one on the wire.
  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          pay_d   = bus.i_req_payload;
          cnt_d   = (bus.i_req_kind == KIND_WORD)
                    ? CW'(WORD_BYTES) : CW'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.i_tx_done) state_d = GAP;
      end
      GAP: begin
        if (!bus.i_tx_done) begin
          if (cnt_q > CW'(1)) begin
            cnt_d   = cnt_q - CW'(1);
            pay_d   = pay_q >> 8;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_tx_start  = (state_q == SEND);
  assign bus.o_tx_data   = pay_q[7:0];

  uart_rx_word_assembler #(
    .WORD_BYTES     (WORD_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_rx_valid      (bus.i_rx_valid),
    .i_rx_data       (bus.i_rx_data),
    .o_rx_word       (bus.o_rx_word),
    .o_rx_word_valid (bus.o_rx_word_valid),
    .o_rx_timeout    (bus.o_rx_timeout)
  );

endmodule

// File: tb/tb_uart_host_link.sv
// Bench for uart_host_link: uart_tx responder, byte/word reference
// model built from the link rules, directed plus random traffic.
module tb_uart_host_link;

  localparam int WB = 4;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_host_link_if #(.WORD_BYTES(WB)) bus();

  uart_host_link #(
    .WORD_BYTES     (WB),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  tx_log[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] got_words[$];
  logic [31:0] exp_words[$];
  int          got_tmo = 0;
  int          exp_tmo = 0;
  logic [31:0] part_w = '0;
  int          part_n = 0;
  int          last_cyc = 0;
  int          last_wait = 0;
  int          tx_phase = 0;
  int          tx_wait = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: raises done after a random frame time, drops it
  // a random time after start falls.
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        bus.i_tx_done = 1'b0;
        tx_phase = 0;
      end else if (tx_phase == 0) begin
        if (bus.o_tx_start) begin
          tx_log.push_back(bus.o_tx_data);
          tx_wait = $urandom_range(0, 3);
          tx_phase = 1;
        end
      end else if (tx_phase == 1) begin
        if (tx_wait == 0) begin
          bus.i_tx_done = 1'b1;
          tx_phase = 2;
        end else tx_wait--;
      end else if (tx_phase == 2) begin
        if (!bus.o_tx_start) begin
          chk("tx_data_stable", 64'(bus.o_tx_data), 64'(tx_log[$]));
          tx_wait = $urandom_range(0, 3);
          tx_phase = 3;
        end
      end else begin
        if (tx_wait == 0) begin
          bus.i_tx_done = 1'b0;
          tx_phase = 0;
        end else tx_wait--;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_rx_word_valid) got_words.push_back(bus.o_rx_word);
        if (bus.o_rx_timeout) got_tmo++;
      end
    end
  end

  task automatic tx_req(input logic kind, input logic [31:0] p);
    int b = 0;
    bus.i_req_valid = 1'b1;
    bus.i_req_kind = kind;
    bus.i_req_payload = p;
    @(negedge clk);
    while (!bus.o_req_ready && b < 2000) begin
      @(negedge clk);
      b++;
    end
    last_wait = b;
    chk("req_accept_bound", 64'(b < 2000), 64'(1));
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    if (kind) for (int i = 0; i < WB; i++) exp_tx.push_back(p[8*i +: 8]);
    else exp_tx.push_back(p[7:0]);
  endtask

  task automatic tx_drain();
    int b = 0;
    @(negedge clk);
    while (!(bus.o_req_ready && tx_phase == 0 && !bus.i_tx_done) &&
           b < 4000) begin
      @(negedge clk);
      b++;
    end
    chk("tx_drain_bound", 64'(b < 4000), 64'(1));
    chk("tx_byte_count", 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk("tx_byte", 64'(tx_log[i]), 64'(exp_tx[i]));
    tx_log.delete();
    exp_tx.delete();
    @(posedge clk); #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    if (part_n > 0 && (c - last_cyc - 1) > T) begin
      exp_tmo++;
      part_n = 0;
      part_w = '0;
    end
    part_w[8*part_n +: 8] = b;
    part_n++;
    last_cyc = c;
    if (part_n == WB) begin
      exp_words.push_back(part_w);
      part_n = 0;
      part_w = '0;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    bus.i_rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data = b;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
    model_byte(b, cyc);
  endtask

  task automatic rx_flush(input int n);
    repeat (n) begin @(posedge clk); #1; end
    if (part_n > 0 && (cyc - last_cyc) > T) begin
      exp_tmo++;
      part_n = 0;
      part_w = '0;
    end
  endtask

  task automatic rx_compare();
    rx_flush(3);
    chk("rx_word_count", 64'(got_words.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
      chk("rx_word", 64'(got_words[i]), 64'(exp_words[i]));
    chk("rx_timeouts", 64'(got_tmo), 64'(exp_tmo));
    got_words.delete();
    exp_words.delete();
    got_tmo = 0;
    exp_tmo = 0;
  endtask

  initial begin
    int w;
    int gaps[9] = '{0, 0, 1, 2, 5, 15, 16, 17, 25};
    bus.i_req_valid = 1'b0;
    bus.i_req_kind = 1'b0;
    bus.i_req_payload = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_req_ready), 64'(1));
    chk("rst_tx_start", 64'(bus.o_tx_start), 64'(0));
    chk("rst_tx_data", 64'(bus.o_tx_data), 64'(0));
    chk("rst_rx_word", 64'(bus.o_rx_word), 64'(0));
    chk("rst_rx_valid", 64'(bus.o_rx_word_valid), 64'(0));
    chk("rst_rx_timeout", 64'(bus.o_rx_timeout), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.o_req_ready), 64'(1));
    chk("post_rst_tx_start", 64'(bus.o_tx_start), 64'(0));
    @(posedge clk); #1;

    tx_req(1'b0, 32'h0000_0008);
    @(negedge clk);
    chk("cmd_start_next_cycle", 64'(bus.o_tx_start), 64'(1));
    chk("cmd_ready_low", 64'(bus.o_req_ready), 64'(0));
    tx_drain();

    tx_req(1'b1, 32'h3C01_0003);
    bus.i_req_valid = 1'b1;
    bus.i_req_kind = 1'b0;
    bus.i_req_payload = 32'h0000_000D;
    w = 0;
    @(negedge clk);
    while (!bus.o_req_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("held_req_after_4_bytes", 64'(tx_log.size()), 64'(4));
    chk("held_req_start_low", 64'(bus.o_tx_start), 64'(0));
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    exp_tx.push_back(8'h0D);
    tx_drain();

    for (int i = 0; i < 8; i++)
      tx_req(1'($urandom_range(0, 1)), 32'($urandom));
    tx_drain();

    rx_byte(8'h21, 2);
    rx_byte(8'h18, 0);
    rx_byte(8'h22, 0);
    rx_byte(8'h00, 0);
    @(negedge clk);
    chk("rx_word_valid_n1", 64'(bus.o_rx_word_valid), 64'(1));
    chk("rx_word_value", 64'(bus.o_rx_word), 64'h0022_1821);
    @(negedge clk);
    chk("rx_word_valid_pulse", 64'(bus.o_rx_word_valid), 64'(0));
    @(posedge clk); #1;

    rx_byte(8'hAA, 3);
    rx_byte(8'hBB, 0);
    rx_flush(16);
    @(negedge clk);
    chk("tmo_not_yet", 64'(bus.o_rx_timeout), 64'(0));
    rx_flush(1);
    @(negedge clk);
    chk("tmo_pulse", 64'(bus.o_rx_timeout), 64'(1));
    chk("tmo_no_word", 64'(bus.o_rx_word_valid), 64'(0));
    @(negedge clk);
    chk("tmo_one_cycle", 64'(bus.o_rx_timeout), 64'(0));
    @(posedge clk); #1;
    rx_byte(8'h01, 0);
    rx_byte(8'h02, 0);
    rx_byte(8'h03, 0);
    rx_byte(8'h04, 0);
    @(negedge clk);
    chk("rx_after_tmo", 64'(bus.o_rx_word), 64'h0403_0201);
    @(posedge clk); #1;
    rx_byte(8'h10, 0);
    rx_byte(8'h20, 0);
    rx_byte(8'h30, T);
    rx_byte(8'h40, T);
    @(negedge clk);
    chk("rx_byte_on_expiry", 64'(bus.o_rx_word), 64'h4030_2010);
    @(posedge clk); #1;
    rx_compare();

    for (int i = 0; i < 40; i++)
      rx_byte(8'($urandom), gaps[$urandom_range(0, 8)]);
    rx_flush(T + 4);
    rx_compare();

    tx_req(1'b1, 32'h1122_3344);
    rx_byte(8'h5A, 0);
    rx_byte(8'hA5, 0);
    w = 0;
    while (tx_log.size() < 2 && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("mid_tx_second_byte", 64'(tx_log.size() >= 2), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.o_req_ready), 64'(1));
    chk("abort_tx_start", 64'(bus.o_tx_start), 64'(0));
    chk("abort_tx_data", 64'(bus.o_tx_data), 64'(0));
    chk("abort_rx_word", 64'(bus.o_rx_word), 64'(0));
    chk("abort_rx_valid", 64'(bus.o_rx_word_valid), 64'(0));
    chk("abort_rx_timeout", 64'(bus.o_rx_timeout), 64'(0));
    part_n = 0;
    part_w = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_log.delete();
    exp_tx.delete();
    got_words.delete();
    got_tmo = 0;
    @(negedge clk);
    chk("post_abort_ready", 64'(bus.o_req_ready), 64'(1));
    chk("post_abort_start", 64'(bus.o_tx_start), 64'(0));
    @(posedge clk); #1;
    rx_byte(8'hC1, 0);
    rx_byte(8'hC2, 0);
    rx_byte(8'hC3, 0);
    rx_byte(8'hC4, 0);
    @(negedge clk);
    chk("post_abort_word", 64'(bus.o_rx_word), 64'hC4C3_C2C1);
    @(posedge clk); #1;
    rx_compare();
    tx_req(1'b0, 32'h0000_000D);
    chk("post_abort_accept_now", 64'(last_wait), 64'(0));
    tx_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
